// File: rtl/execute_stage_pipe.sv
// Execute stage: operand forwarding, single-cycle ALU, a shift-add multiplier
// that stalls decode while it runs, and the EX/MEM output register.
//
// state | meaning
// IDLE  | accepting ops; single-cycle ops load EX/MEM directly
// MUL   | one shift-add step per cycle, DATA_W steps in total
// DONE  | product ready; waits for EX/MEM to be free, then loads it
module execute_stage_pipe #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int SH_W   = 4,
    parameter int MUL_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_op,
    input  logic [REG_AW-1:0] rdst_addr,
    input  logic [REG_AW-1:0] rsrc_addr,
    input  logic [DATA_W-1:0] rdst_data,
    input  logic [DATA_W-1:0] rsrc_data,
    input  logic              use_imm,
    input  logic [DATA_W-1:0] imm,
    input  logic [SH_W-1:0]   shamt,
    input  logic              flag_en,
    input  logic              wb_en_in,
    input  logic [REG_AW-1:0] wb_addr_in,
    input  logic              mem_wb_we,
    input  logic [REG_AW-1:0] mem_wb_addr,
    input  logic [DATA_W-1:0] mem_wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              wb_en_out,
    output logic [REG_AW-1:0] wb_addr_out,
    output logic [2:0]        flags,
    output logic              busy
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;
    state_t state, state_nxt;

    logic              accept, is_mul, load_single, done_load;
    logic [DATA_W-1:0] op1, op2, fwd_src;
    logic [DATA_W:0]   add_x, sub_x, inc_x, dec_x, shl_x, shr_x;
    logic [31:0]       sa;
    logic [DATA_W-1:0] alu_res, nz_src;
    logic              c_new, c_upd, nz_upd;
    logic [2:0]        f_next;

    logic [2*DATA_W-1:0] acc, mcand;
    logic [DATA_W-1:0]   mplier;
    logic [CNT_W-1:0]    cnt;
    logic                mul_wb_en, mul_flag_en;
    logic [REG_AW-1:0]   mul_wb_addr;

    assign busy        = (state != ST_IDLE);
    assign in_ready    = !busy && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready && !flush;
    assign is_mul      = (alu_op == 4'd13) && (MUL_EN != 0);
    assign load_single = accept && !is_mul;
    assign done_load   = (state == ST_DONE) && (!out_valid || out_ready) && !flush;

    // EX/MEM has priority over MEM/WB because it holds the younger value
    assign op1 = (out_valid && wb_en_out && (wb_addr_out == rdst_addr)) ? result :
                 (mem_wb_we && (mem_wb_addr == rdst_addr)) ? mem_wb_data : rdst_data;
    assign fwd_src = (out_valid && wb_en_out && (wb_addr_out == rsrc_addr)) ? result :
                     (mem_wb_we && (mem_wb_addr == rsrc_addr)) ? mem_wb_data : rsrc_data;
    assign op2 = use_imm ? imm : fwd_src;

    assign add_x = {1'b0, op1} + {1'b0, op2};
    assign sub_x = {1'b0, op1} - {1'b0, op2};
    assign inc_x = {1'b0, op1} + 1'b1;
    assign dec_x = {1'b0, op1} - 1'b1;
    assign sa    = 32'(shamt) % 32'(DATA_W);
    // the extra bit on each shifter catches the last bit shifted out
    assign shl_x = {1'b0, op1} << sa;
    assign shr_x = {op1, 1'b0} >> sa;

    // single-cycle ALU result and which flags it touches
    always_comb begin
        alu_res = '0;
        c_new   = flags[2];
        c_upd   = 1'b0;
        nz_upd  = 1'b0;
        case (alu_op)
            4'd1:  begin alu_res = op2; nz_upd = 1'b1; end
            4'd2:  begin alu_res = add_x[DATA_W-1:0]; c_new = add_x[DATA_W]; c_upd = 1'b1; nz_upd = 1'b1; end
            4'd3:  begin alu_res = sub_x[DATA_W-1:0]; c_new = sub_x[DATA_W]; c_upd = 1'b1; nz_upd = 1'b1; end
            4'd4:  begin alu_res = op1 & op2; nz_upd = 1'b1; end
            4'd5:  begin alu_res = op1 | op2; nz_upd = 1'b1; end
            4'd6:  begin alu_res = ~op1; nz_upd = 1'b1; end
            4'd7:  begin alu_res = inc_x[DATA_W-1:0]; c_new = inc_x[DATA_W]; c_upd = 1'b1; nz_upd = 1'b1; end
            4'd8:  begin alu_res = dec_x[DATA_W-1:0]; c_new = dec_x[DATA_W]; c_upd = 1'b1; nz_upd = 1'b1; end
            4'd9:  begin alu_res = shl_x[DATA_W-1:0]; c_new = shl_x[DATA_W]; c_upd = (sa != 0); nz_upd = 1'b1; end
            4'd10: begin alu_res = shr_x[DATA_W:1]; c_new = shr_x[0]; c_upd = (sa != 0); nz_upd = 1'b1; end
            4'd11: begin c_new = 1'b1; c_upd = 1'b1; end
            4'd12: begin c_new = 1'b0; c_upd = 1'b1; end
            4'd14: begin alu_res = op1; c_new = sub_x[DATA_W]; c_upd = 1'b1; nz_upd = 1'b1; end
            default: ;
        endcase
        // CMP reports on the difference while passing op1 through
        nz_src = (alu_op == 4'd14) ? sub_x[DATA_W-1:0] : alu_res;
    end

    assign f_next = {c_upd ? c_new : flags[2],
                     nz_upd ? nz_src[DATA_W-1] : flags[1],
                     nz_upd ? ~|nz_src : flags[0]};

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // FSM next state; flush aborts from any state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept && is_mul) state_nxt = ST_MUL;
            ST_MUL:  if (cnt == '0) state_nxt = ST_DONE;
            ST_DONE: if (done_load) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    // multiplier datapath: operands latched at accept, one partial product per cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            cnt         <= '0;
            mul_wb_en   <= 1'b0;
            mul_wb_addr <= '0;
            mul_flag_en <= 1'b0;
        end else if (state == ST_IDLE && accept && is_mul) begin
            acc         <= '0;
            mcand       <= {{DATA_W{1'b0}}, op1};
            mplier      <= op2;
            cnt         <= CNT_W'(DATA_W - 1);
            mul_wb_en   <= wb_en_in;
            mul_wb_addr <= wb_addr_in;
            mul_flag_en <= flag_en;
        end else if (state == ST_MUL) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
        end
    end

    // EX/MEM register and flags; holds while the memory stage stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            result      <= '0;
            wb_en_out   <= 1'b0;
            wb_addr_out <= '0;
            flags       <= '0;
        end else if (load_single) begin
            out_valid   <= 1'b1;
            result      <= alu_res;
            wb_en_out   <= wb_en_in;
            wb_addr_out <= wb_addr_in;
            if (flag_en) flags <= f_next;
        end else if (done_load) begin
            out_valid   <= 1'b1;
            result      <= acc[DATA_W-1:0];
            wb_en_out   <= mul_wb_en;
            wb_addr_out <= mul_wb_addr;
            if (mul_flag_en)
                flags <= {|acc[2*DATA_W-1:DATA_W], acc[DATA_W-1], ~|acc[DATA_W-1:0]};
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_execute_stage_pipe.sv
// Bench for execute_stage_pipe: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_execute_stage_pipe;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, use_imm, flag_en, wb_en_in;
    logic [3:0]    alu_op;
    logic [AW-1:0] rdst_addr, rsrc_addr, wb_addr_in, mem_wb_addr, wb_addr_out;
    logic [DW-1:0] rdst_data, rsrc_data, imm, mem_wb_data, result;
    logic [SW-1:0] shamt;
    logic          mem_wb_we, out_valid, out_ready, wb_en_out, busy;
    logic [2:0]    flags;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic          m_valid, m_wben, m_busy;
    logic [DW-1:0] m_res;
    logic [AW-1:0] m_wbaddr;
    logic [2:0]    m_flags;
    int            m_cnt;
    logic [DW-1:0] p_res;
    logic [2:0]    p_flags_new;
    logic          p_fe, p_wben;
    logic [AW-1:0] p_wbaddr;

    execute_stage_pipe #(.DATA_W(DW), .REG_AW(AW), .SH_W(SW), .MUL_EN(1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .rdst_addr(rdst_addr), .rsrc_addr(rsrc_addr),
        .rdst_data(rdst_data), .rsrc_data(rsrc_data), .use_imm(use_imm), .imm(imm),
        .shamt(shamt), .flag_en(flag_en), .wb_en_in(wb_en_in), .wb_addr_in(wb_addr_in),
        .mem_wb_we(mem_wb_we), .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .wb_en_out(wb_en_out), .wb_addr_out(wb_addr_out), .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] fwd(input logic [AW-1:0] a, input logic [DW-1:0] rf);
        if (m_valid && m_wben && m_wbaddr == a) return m_res;
        if (mem_wb_we && mem_wb_addr == a)      return mem_wb_data;
        return rf;
    endfunction

    // arithmetic definition of each single-cycle op
    function automatic void ref_op(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input int s, input logic fe, input logic [2:0] fin,
                                   output logic [DW-1:0] r, output logic [2:0] fout);
        logic c, cu, nzu;
        logic [DW-1:0] z;
        int unsigned wide;
        r = '0; c = fin[2]; cu = 1'b0; nzu = 1'b0;
        case (op)
            4'd1:  begin r = b; nzu = 1'b1; end
            4'd2:  begin wide = 32'(a) + 32'(b); r = 16'(wide); c = (wide > 32'hFFFF); cu = 1'b1; nzu = 1'b1; end
            4'd3:  begin r = a - b; c = (a < b); cu = 1'b1; nzu = 1'b1; end
            4'd4:  begin r = a & b; nzu = 1'b1; end
            4'd5:  begin r = a | b; nzu = 1'b1; end
            4'd6:  begin r = ~a; nzu = 1'b1; end
            4'd7:  begin r = a + 16'd1; c = (a == 16'hFFFF); cu = 1'b1; nzu = 1'b1; end
            4'd8:  begin r = a - 16'd1; c = (a == 16'h0000); cu = 1'b1; nzu = 1'b1; end
            4'd9:  begin r = a << s; nzu = 1'b1; if (s != 0) begin c = a[DW-s]; cu = 1'b1; end end
            4'd10: begin r = a >> s; nzu = 1'b1; if (s != 0) begin c = a[s-1]; cu = 1'b1; end end
            4'd11: begin c = 1'b1; cu = 1'b1; end
            4'd12: begin c = 1'b0; cu = 1'b1; end
            4'd14: begin r = a; c = (a < b); cu = 1'b1; nzu = 1'b1; end
            default: ;
        endcase
        z = (op == 4'd14) ? a - b : r;
        fout = fin;
        if (fe) begin
            if (cu) fout[2] = c;
            if (nzu) begin fout[1] = z[DW-1]; fout[0] = (z == '0); end
        end
    endfunction

    task automatic model_reset();
        m_valid = 0; m_wben = 0; m_busy = 0; m_res = '0; m_wbaddr = '0; m_flags = '0; m_cnt = 0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".result"}, 32'(result), 32'(m_res));
        check({tag, ".wb_en_out"}, 32'(wb_en_out), 32'(m_wben));
        check({tag, ".wb_addr_out"}, 32'(wb_addr_out), 32'(m_wbaddr));
        check({tag, ".flags"}, 32'(flags), 32'(m_flags));
        check({tag, ".busy"}, 32'(busy), 32'(m_busy));
    endtask

    // one clock: check handshake, advance the model, check registered outputs
    task automatic cycle(input string tag);
        logic rdy, acc, ld;
        logic [DW-1:0] a, b, r;
        logic [2:0] f;
        longint unsigned prod;
        #1;
        rdy = !m_busy && (!m_valid || out_ready);
        check({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        acc = in_valid && rdy && !flush;
        a = fwd(rdst_addr, rdst_data);
        b = use_imm ? imm : fwd(rsrc_addr, rsrc_data);
        ld = 1'b0;
        if (flush) begin
            m_busy = 0;
        end else if (m_busy) begin
            if (m_cnt > 0) m_cnt--;
            else if (!m_valid || out_ready) begin
                ld = 1'b1; m_busy = 0;
                m_res = p_res; m_wben = p_wben; m_wbaddr = p_wbaddr;
                if (p_fe) m_flags = p_flags_new;
            end
        end else if (acc && alu_op == 4'd13) begin
            prod = longint'(a) * longint'(b);
            p_res = prod[15:0];
            p_flags_new = {prod[31:16] != 0, prod[15], prod[15:0] == 0};
            p_fe = flag_en; p_wben = wb_en_in; p_wbaddr = wb_addr_in;
            m_busy = 1; m_cnt = DW;
        end else if (acc) begin
            ref_op(alu_op, a, b, int'(shamt) % DW, flag_en, m_flags, r, f);
            ld = 1'b1; m_res = r; m_flags = f; m_wben = wb_en_in; m_wbaddr = wb_addr_in;
        end
        if (ld) m_valid = 1;
        else if (flush || out_ready) m_valid = 0;
        @(posedge clk); #1;
        check_regs(tag);
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                         input logic [DW-1:0] rdd, input logic [DW-1:0] rsd, input logic ui,
                         input logic [DW-1:0] im, input logic [SW-1:0] sh, input logic fe,
                         input logic we, input logic [AW-1:0] wa);
        in_valid = v; alu_op = op; rdst_addr = rd; rsrc_addr = rs; rdst_data = rdd; rsrc_data = rsd;
        use_imm = ui; imm = im; shamt = sh; flag_en = fe; wb_en_in = we; wb_addr_in = wa;
    endtask

    task automatic idle(input string tag);
        in_valid = 0; out_ready = 1; mem_wb_we = 0; flush = 0;
        cycle(tag);
    endtask

    task automatic do_reset(input string tag);
        #2; reset = 0; #1;
        model_reset();
        check_regs(tag);
        @(posedge clk); #1; reset = 1;
        #1;
        check({tag, ".in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    logic [2:0] f_snap;

    initial begin
        reset = 1; flush = 0; out_ready = 1; mem_wb_we = 0; mem_wb_addr = '0; mem_wb_data = '0;
        drive(0, 4'd0, 3'd0, 3'd0, 16'h0, 16'h0, 0, 16'h0, 4'd0, 0, 0, 3'd0);
        model_reset();
        @(posedge clk); #1;
        do_reset("init");

        // T2 ADD with carry out to zero
        drive(1, 4'd2, 3'd1, 3'd2, 16'hFFFF, 16'h0001, 0, 16'h0, 4'd0, 1, 1, 3'd1);
        cycle("t2");
        check("t2.result_const", 32'(result), 32'h0000);
        check("t2.flags_const", 32'(flags), 32'b101);

        // T3 forwarding: EX/MEM, MEM/WB only, then both matching
        idle("t3.gap0");
        drive(1, 4'd2, 3'd1, 3'd2, 16'h0010, 16'h0005, 0, 16'h0, 4'd0, 1, 1, 3'd3);
        cycle("t3.add");
        drive(1, 4'd3, 3'd3, 3'd1, 16'hDEAD, 16'h0010, 0, 16'h0, 4'd0, 1, 1, 3'd4);
        cycle("t3.sub_exmem");
        check("t3.exmem_const", 32'(result), 32'h0005);
        idle("t3.gap1");
        mem_wb_we = 1; mem_wb_addr = 3'd3; mem_wb_data = 16'h0100;
        drive(1, 4'd3, 3'd3, 3'd1, 16'hDEAD, 16'h0010, 0, 16'h0, 4'd0, 1, 1, 3'd4);
        cycle("t3.sub_memwb");
        check("t3.memwb_const", 32'(result), 32'h00F0);
        mem_wb_we = 0;
        drive(1, 4'd2, 3'd1, 3'd2, 16'h0007, 16'h0001, 0, 16'h0, 4'd0, 1, 1, 3'd5);
        cycle("t3.add2");
        mem_wb_we = 1; mem_wb_addr = 3'd5; mem_wb_data = 16'h1234;
        drive(1, 4'd3, 3'd5, 3'd1, 16'hBEEF, 16'h0003, 0, 16'h0, 4'd0, 1, 1, 3'd6);
        cycle("t3.sub_both");
        check("t3.both_const", 32'(result), 32'h0005);
        idle("t3.gap2");

        // T4 MUL latency and back-pressure, with a competing op held on the input
        drive(1, 4'd13, 3'd1, 3'd2, 16'h0123, 16'h0100, 0, 16'h0, 4'd0, 1, 1, 3'd6);
        cycle("t4.accept");
        drive(1, 4'd2, 3'd1, 3'd2, 16'h1111, 16'h2222, 0, 16'h0, 4'd0, 1, 1, 3'd7);
        for (int i = 1; i <= 16; i++) begin
            cycle("t4.run");
            check("t4.busy_const", 32'(busy), 32'd1);
            check("t4.ov_const", 32'(out_valid), 32'd0);
        end
        cycle("t4.done");
        check("t4.result_const", 32'(result), 32'h2300);
        check("t4.flags_const", 32'(flags), 32'b100);
        check("t4.ov_done", 32'(out_valid), 32'd1);
        idle("t4.gap");

        // T5 output stall with a pending op, then release
        drive(1, 4'd1, 3'd0, 3'd0, 16'h0, 16'h0, 1, 16'h00AA, 4'd0, 1, 1, 3'd7);
        cycle("t5.first");
        out_ready = 0;
        drive(1, 4'd1, 3'd0, 3'd0, 16'h0, 16'h0, 1, 16'h0055, 4'd0, 1, 1, 3'd2);
        for (int i = 0; i < 5; i++) begin
            cycle("t5.stall");
            check("t5.hold_const", 32'(result), 32'h00AA);
        end
        out_ready = 1;
        cycle("t5.release");
        check("t5.second_const", 32'(result), 32'h0055);
        in_valid = 0;
        cycle("t5.drain");
        check("t5.no_dup", 32'(out_valid), 32'd0);

        // T6 flush during MUL with a competing op on the input
        drive(1, 4'd13, 3'd1, 3'd2, 16'h00FF, 16'h00FF, 0, 16'h0, 4'd0, 1, 1, 3'd3);
        cycle("t6.accept");
        drive(1, 4'd2, 3'd1, 3'd2, 16'h0001, 16'h0001, 0, 16'h0, 4'd0, 1, 1, 3'd4);
        for (int i = 1; i < 8; i++) cycle("t6.run");
        f_snap = m_flags;
        flush = 1;
        cycle("t6.flush");
        check("t6.busy_const", 32'(busy), 32'd0);
        check("t6.ov_const", 32'(out_valid), 32'd0);
        check("t6.flags_kept", 32'(flags), 32'(f_snap));
        flush = 0; in_valid = 0;
        cycle("t6.after");
        check("t6.nothing_accepted", 32'(out_valid), 32'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom),
                  16'($urandom), 16'($urandom), 1'($urandom), 16'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom), 3'($urandom));
            mem_wb_we = 1'($urandom); mem_wb_addr = 3'($urandom); mem_wb_data = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 24) == 0);
            cycle("rnd");
        end
        flush = 0;

        // T1 reset in the middle of a MUL
        idle("t1.gap");
        drive(1, 4'd13, 3'd1, 3'd2, 16'h0F0F, 16'h0033, 0, 16'h0, 4'd0, 1, 1, 3'd1);
        cycle("t1.accept");
        in_valid = 0;
        for (int i = 0; i < 5; i++) cycle("t1.run");
        do_reset("t1.reset");
        drive(1, 4'd7, 3'd1, 3'd0, 16'h7FFF, 16'h0, 0, 16'h0, 4'd0, 1, 1, 3'd2);
        cycle("t1.post");
        check("t1.post_const", 32'(result), 32'h8000);
        check("t1.post_flags", 32'(flags), 32'b010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
